// File: rtl/axi_round_clip_pkg.sv
// Shared rounding-mode encodings and width helpers for the multi-lane round/clip block.
package axi_round_clip_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC   = 2'd0,
        MODE_HALF_UP = 2'd1,
        MODE_CONV    = 2'd2,
        MODE_RSVD    = 2'd3
    } rnd_mode_e;

    // Width of the rounded intermediate: one guard bit above the kept integer part.
    function automatic int round_width(input int width_in, input int rnd_bits);
        return width_in - rnd_bits + 1;
    endfunction

endpackage

// File: rtl/round_clip_lane.sv
// One signed lane: S1 rounds away RND_BITS LSBs, S2 clips or wraps to WIDTH_OUT.
module round_clip_lane
    import axi_round_clip_pkg::*;
#(
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int RND_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en1,
    input  logic                        en2,
    input  rnd_mode_e                   mode,
    input  logic                        sat_en,
    input  logic                        vld,
    input  logic signed [WIDTH_IN-1:0]  din,
    output logic [WIDTH_OUT-1:0]        dout,
    output logic                        sat
);

    localparam int R = round_width(WIDTH_IN, RND_BITS);
    localparam logic signed [WIDTH_IN:0] HALF = ((WIDTH_IN+1)'(1) << RND_BITS) >> 1;
    localparam logic signed [WIDTH_IN:0] ONE  = (WIDTH_IN+1)'(1);

    function automatic logic signed [R-1:0] round_val(input logic signed [WIDTH_IN-1:0] x,
                                                      input rnd_mode_e m);
        logic signed [WIDTH_IN:0] xe;
        logic signed [WIDTH_IN:0] bias;
        logic signed [WIDTH_IN:0] sum;
        xe = x;
        case (m)
            MODE_HALF_UP: bias = HALF;
            MODE_CONV:    bias = HALF - ONE + $signed({{WIDTH_IN{1'b0}}, x[RND_BITS]});
            default:      bias = '0;
        endcase
        if (RND_BITS == 0) bias = '0;
        sum = xe + bias;
        return R'(sum >>> RND_BITS);
    endfunction

    // Overflow when the bits above the output sign bit are not a pure sign extension.
    function automatic void clip_val(input logic signed [R-1:0] v, input logic sen,
                                     output logic [WIDTH_OUT-1:0] d, output logic ovf);
        logic [R-WIDTH_OUT:0] hi;
        hi  = v[R-1:WIDTH_OUT-1];
        ovf = !((&hi) || !(|hi));
        if (ovf && sen)
            d = v[R-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}};
        else
            d = v[WIDTH_OUT-1:0];
    endfunction

    logic signed [R-1:0]  rnd_p1;
    logic [WIDTH_OUT-1:0] clip_d;
    logic                 clip_ovf;

    // S1: rounding
    always_ff @(posedge clk) begin
        if (en1) rnd_p1 <= round_val(din, mode);
    end

    always_comb begin
        clip_d   = '0;
        clip_ovf = 1'b0;
        clip_val(rnd_p1, sat_en, clip_d, clip_ovf);
    end

    // S2: clip/wrap and saturation flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout <= '0;
            sat  <= 1'b0;
        end else if (en2) begin
            dout <= clip_d;
            sat  <= vld & clip_ovf;
        end
    end

endmodule

// File: rtl/axi_round_clip_multi.sv
// AXI-stream multi-lane round/saturate with per-packet mode latch and saturation counter.
module axi_round_clip_multi
    import axi_round_clip_pkg::*;
#(
    parameter int WIDTH_IN  = 24,
    parameter int WIDTH_OUT = 16,
    parameter int RND_BITS  = 8,
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     mode,
    input  logic                           sat_en,
    input  logic                           clear_cnt,
    input  logic [NUM_LANES*WIDTH_IN-1:0]  i_tdata,
    input  logic                           i_tlast,
    input  logic                           i_tvalid,
    output logic                           i_tready,
    output logic [NUM_LANES*WIDTH_OUT-1:0] o_tdata,
    output logic                           o_tlast,
    output logic                           o_tvalid,
    input  logic                           o_tready,
    output logic [CNT_W-1:0]               sat_count,
    output logic                           sat_flag
);

    if (WIDTH_IN - RND_BITS < WIDTH_OUT) begin : g_bad_widths
        $error("axi_round_clip_multi: WIDTH_IN - RND_BITS must be >= WIDTH_OUT");
    end

    logic            vld_p1, vld_p2;
    logic            last_p1, last_p2;
    logic            sat_en_p1;
    logic            first;
    logic [1:0]      mode_q;
    logic            sat_en_q;
    logic            en1, en2, acc;
    logic [1:0]      eff_mode;
    logic            eff_sat;
    logic [NUM_LANES-1:0] lane_sat;

    assign en2      = o_tready | ~vld_p2;
    assign en1      = en2 | ~vld_p1;
    assign i_tready = en1;
    assign acc      = i_tvalid & en1;

    // The packet's first beat uses the live controls; later beats use the latched copy.
    assign eff_mode = first ? mode : mode_q;
    assign eff_sat  = first ? sat_en : sat_en_q;

    assign o_tvalid = vld_p2;
    assign o_tlast  = last_p2;
    assign sat_flag = |lane_sat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
            first     <= 1'b1;
            mode_q    <= MODE_TRUNC;
            sat_en_q  <= 1'b1;
            sat_count <= '0;
        end else begin
            if (acc) begin
                first <= i_tlast;
                if (first) begin
                    mode_q   <= mode;
                    sat_en_q <= sat_en;
                end
            end
            if (en1) vld_p1 <= i_tvalid;
            if (en2) begin
                vld_p2  <= vld_p1;
                last_p2 <= last_p1;
            end
            if (clear_cnt)
                sat_count <= '0;
            else if (vld_p2 && o_tready && sat_flag && sat_count != '1)
                sat_count <= sat_count + CNT_W'(1);
        end
    end

    // S1 sideband: tlast and the S2 clip policy travel with the data
    always_ff @(posedge clk) begin
        if (en1) begin
            last_p1   <= i_tlast;
            sat_en_p1 <= eff_sat;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        round_clip_lane #(
            .WIDTH_IN  (WIDTH_IN),
            .WIDTH_OUT (WIDTH_OUT),
            .RND_BITS  (RND_BITS)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en1     (en1),
            .en2     (en2),
            .mode    (rnd_mode_e'(eff_mode)),
            .sat_en  (sat_en_p1),
            .vld     (vld_p1),
            .din     (i_tdata[(NUM_LANES-1-g)*WIDTH_IN +: WIDTH_IN]),
            .dout    (o_tdata[(NUM_LANES-1-g)*WIDTH_OUT +: WIDTH_OUT]),
            .sat     (lane_sat[g])
        );
    end

endmodule

// File: tb/tb_axi_round_clip_multi.sv
// Randomized and directed bench for axi_round_clip_multi against an arithmetic reference model.
module tb_axi_round_clip_multi;

    localparam int WIDTH_IN  = 24;
    localparam int WIDTH_OUT = 16;
    localparam int RND_BITS  = 8;
    localparam int NUM_LANES = 2;
    // Narrow counter keeps the sticky-at-all-ones case short.
    localparam int CNT_W     = 8;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        sat_en = 1'b1;
    logic        clear_cnt = 1'b0;
    logic [47:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [CNT_W-1:0] sat_count;
    logic        sat_flag;

    axi_round_clip_multi #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .RND_BITS  (RND_BITS),
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .sat_en    (sat_en),
        .clear_cnt (clear_cnt),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .sat_count (sat_count),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: floor division plus remainder inspection.
    function automatic longint round_model(input longint x, input int m);
        longint step, q, r;
        step = longint'(1) << RND_BITS;
        q = x / step;
        if ((x % step) != 0 && x < 0) q = q - 1;
        r = x - q * step;
        if (m == 1 && 2 * r >= step) q = q + 1;
        else if (m == 2 && (2 * r > step || (2 * r == step && q[0]))) q = q + 1;
        return q;
    endfunction

    function automatic void clip_model(input longint v, input logic s,
                                       output logic [WIDTH_OUT-1:0] d, output logic ovf);
        longint mx, mn;
        mx = (longint'(1) << (WIDTH_OUT - 1)) - 1;
        mn = -(longint'(1) << (WIDTH_OUT - 1));
        ovf = (v > mx) || (v < mn);
        if (ovf && s) d = (v > mx) ? 16'h7FFF : 16'h8000;
        else          d = WIDTH_OUT'(v);
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    logic        m_first = 1'b1;
    int          m_mode = 0;
    logic        m_sat = 1'b1;
    longint      mcnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          cyc = 0;

    task automatic push_expected();
        exp_t e;
        longint v0, v1;
        logic [15:0] d0, d1;
        logic s0, s1;
        if (m_first) begin
            m_mode = int'(mode);
            m_sat  = sat_en;
        end
        m_first = i_tlast;
        v0 = round_model(longint'($signed(i_tdata[47:24])), m_mode);
        v1 = round_model(longint'($signed(i_tdata[23:0])), m_mode);
        clip_model(v0, m_sat, d0, s0);
        clip_model(v1, m_sat, d1, s1);
        e.data = {d0, d1};
        e.last = i_tlast;
        e.sat  = s0 | s1;
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            m_first    = 1'b1;
            m_mode     = 0;
            m_sat      = 1'b1;
            mcnt       = 0;
            prev_stall = 1'b0;
        end else begin
            chk("sat_count", 64'(sat_count), 64'(mcnt));
            if (prev_stall) begin
                chk("hold_data", 64'(o_tdata), 64'(prev_data));
                chk("hold_last", 64'(o_tlast), 64'(prev_last));
            end
            if (o_tvalid) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    chk("data", 64'(o_tdata), 64'(sb[0].data));
                    chk("last", 64'(o_tlast), 64'(sb[0].last));
                    chk("sat_flag", 64'(sat_flag), 64'(sb[0].sat));
                    if (o_tready) begin
                        if (!clear_cnt && sb[0].sat && mcnt != CNT_MAX) mcnt = mcnt + 1;
                        obs.push_back(o_tdata);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("sat_flag_idle", 64'(sat_flag), 64'(0));
            end
            if (clear_cnt) mcnt = 0;
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
            if (i_tvalid && i_tready) push_expected();
        end
    end

    logic bp_rand = 1'b0;
    logic rdy_fixed = 1'b1;
    initial o_tready = 1'b1;
    always @(posedge clk) begin
        #2;
        o_tready = bp_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic drive(input logic [23:0] l0, input logic [23:0] l1, input logic last,
                         input logic [1:0] md, input logic se);
        logic ok;
        int n;
        ok = 1'b0;
        n  = 0;
        i_tdata  = {l0, l1};
        i_tlast  = last;
        mode     = md;
        sat_en   = se;
        i_tvalid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = i_tready;
            @(posedge clk);
            #1;
            n++;
        end
        i_tvalid = 1'b0;
        if (!ok) chk("accept", 64'(ok), 64'(1));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || o_tvalid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] l0, l1;
        int t0;

        #200000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [23:0] l0, l1;
        int t0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 64'(o_tvalid), 64'(0));
        chk("rst_tdata", 64'(o_tdata), 64'(0));
        chk("rst_tlast", 64'(o_tlast), 64'(0));
        chk("rst_sat_flag", 64'(sat_flag), 64'(0));
        chk("rst_sat_count", 64'(sat_count), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Half up with latency check
        obs.delete();
        drive(24'h000080, 24'hFFFF80, 1'b1, 2'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_tvalid", 64'(o_tvalid), 64'(1));
        chk("lat_tdata", 64'(o_tdata), 64'h0001_0000);
        @(posedge clk);
        #1;
        drain("drain_halfup");
        chk("halfup_cnt", 64'(sat_count), 64'(0));

        // Convergent, truncate, reserved mode
        obs.delete();
        drive(24'h000080, 24'h000180, 1'b1, 2'd2, 1'b1);
        drive(24'hFFFE80, 24'h000000, 1'b1, 2'd2, 1'b1);
        drive(24'hFFFF80, 24'h000000, 1'b1, 2'd0, 1'b1);
        drive(24'h0001FF, 24'h000000, 1'b1, 2'd3, 1'b1);
        drain("drain_modes");
        chk("conv_n", 64'(obs.size()), 64'(4));
        if (obs.size() == 4) begin
            chk("conv_even", 64'(obs[0]), 64'h0000_0002);
            chk("conv_neg", 64'(obs[1]), 64'hFFFE_0000);
            chk("trunc_neg", 64'(obs[2]), 64'hFFFF_0000);
            chk("mode3_trunc", 64'(obs[3]), 64'h0001_0000);
        end

        // Overflow: saturate then wrap
        obs.delete();
        drive(24'h7FFF80, 24'h800000, 1'b1, 2'd1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("ovf_sat_flag", 64'(sat_flag), 64'(1));
        @(posedge clk);
        #1;
        drive(24'h7FFF80, 24'h800000, 1'b1, 2'd1, 1'b0);
        drain("drain_ovf");
        chk("ovf_n", 64'(obs.size()), 64'(2));
        if (obs.size() == 2) begin
            chk("ovf_clamp", 64'(obs[0]), 64'h7FFF_8000);
            chk("ovf_wrap", 64'(obs[1]), 64'h8000_8000);
        end
        chk("ovf_cnt", 64'(sat_count), 64'(2));

        // Mode change mid-packet has no effect until the next packet
        obs.delete();
        drive(24'h000080, 24'h000080, 1'b0, 2'd2, 1'b1);
        drive(24'h000080, 24'h000080, 1'b0, 2'd2, 1'b1);
        drive(24'h000080, 24'h000080, 1'b0, 2'd1, 1'b1);
        drive(24'h000080, 24'h000080, 1'b1, 2'd1, 1'b1);
        drive(24'h000080, 24'h000080, 1'b1, 2'd1, 1'b1);
        drain("drain_latch");
        chk("latch_n", 64'(obs.size()), 64'(5));
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("latch_beat", 64'(obs[i]), 64'h0);
        if (obs.size() == 5) chk("latch_next_pkt", 64'(obs[4]), 64'h0001_0001);

        // Throughput at o_tready=1
        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            drive(r[23:0], {r[7:0], r[31:16]}, 1'(i == 19), 2'd1, 1'b1);
        end
        chk("throughput_cycles", 64'(cyc - t0), 64'(20));
        drain("drain_tput");

        // clear_cnt coincident with a saturating transfer
        obs.delete();
        chk("pre_clear_nonzero", 64'(sat_count != 0), 64'(1));
        drive(24'h7FFF80, 24'h000000, 1'b1, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        clear_cnt = 1'b1;
        @(posedge clk);
        #1;
        clear_cnt = 1'b0;
        @(negedge clk);
        chk("clear_xfer", 64'(obs.size()), 64'(1));
        chk("clear_priority", 64'(sat_count), 64'(0));

        // Counter sticks at all-ones
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) drive(24'h7FFF80, 24'h000000, 1'b1, 2'd1, 1'b1);
        drain("drain_sticky");
        chk("cnt_sticky", 64'(sat_count), 64'(CNT_MAX));

        // Reset mid-packet with two beats in flight
        rdy_fixed = 1'b0;
        drive(24'h000080, 24'h000080, 1'b0, 2'd2, 1'b1);
        drive(24'h000080, 24'h000080, 1'b0, 2'd2, 1'b1);
        chk("inflight_full", 64'(o_tvalid), 64'(1));
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tvalid", 64'(o_tvalid), 64'(0));
        chk("midrst_cnt", 64'(sat_count), 64'(0));
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        obs.delete();
        drive(24'h000080, 24'h000080, 1'b1, 2'd1, 1'b1);
        drain("drain_midrst");
        chk("midrst_n", 64'(obs.size()), 64'(1));
        if (obs.size() == 1) chk("midrst_new_pkt", 64'(obs[0]), 64'h0001_0001);

        // Random traffic under random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r  = $urandom;
            l0 = r[23:0];
            r  = $urandom;
            l1 = r[23:0];
            if (r[31:30] == 2'b00) l0 = {r[29] ? 8'h7F : 8'h80, r[15:0]};
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            drive(l0, l1, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end
        bp_rand   = 1'b0;
        rdy_fixed = 1'b1;
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
